// File: rtl/wts_i2s_transmitter.sv
// I2S transmitter: converts 12-bit offset-binary stereo samples to signed 16-bit
// left-justified words and shifts them out in Philips I2S format with generated BCLK/LRCK.
`timescale 1ns/1ps
module wts_i2s_transmitter #(
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic        clk,
    input  logic        slot_nreset,
    input  logic [11:0] left_in,
    input  logic [11:0] right_in,
    input  logic        mute,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data,
    output logic        sample_strobe
);

    localparam logic [7:0] DivLast = 8'(BCLK_HALF - 1);

    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  slot_q, slot_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic        strobe_q, strobe_d;
    logic [15:0] lsr_q, lsr_d;
    logic [15:0] rsr_q, rsr_d;
    logic [5:0]  slot_nxt;

    // Offset-binary to two's complement: flip the MSB, then left-justify.
    function automatic logic [15:0] to_word(input logic [11:0] x);
        return {~x[11], x[10:0], 4'b0000};
    endfunction

    assign slot_nxt = slot_q + 6'd1;

    always_comb begin
        div_d    = div_q;
        bclk_d   = bclk_q;
        slot_d   = slot_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        lsr_d    = lsr_q;
        rsr_d    = rsr_q;
        if (div_q == DivLast) begin
            div_d  = 8'd0;
            bclk_d = ~bclk_q;
            if (bclk_q) begin
                slot_d = slot_nxt;
                lrck_d = slot_nxt[5];
                data_d = 1'b0;
                if (slot_nxt == 6'd0) begin
                    strobe_d = 1'b1;
                    lsr_d    = mute ? 16'h0000 : to_word(left_in);
                    rsr_d    = mute ? 16'h0000 : to_word(right_in);
                end else if (slot_nxt >= 6'd1 && slot_nxt <= 6'd16) begin
                    data_d = lsr_q[15];
                    lsr_d  = {lsr_q[14:0], 1'b0};
                end else if (slot_nxt >= 6'd33 && slot_nxt <= 6'd48) begin
                    data_d = rsr_q[15];
                    rsr_d  = {rsr_q[14:0], 1'b0};
                end
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge slot_nreset) begin
        if (!slot_nreset) begin
            div_q    <= 8'd0;
            bclk_q   <= 1'b1;
            slot_q   <= 6'd63;
            lrck_q   <= 1'b1;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            lsr_q    <= 16'h0000;
            rsr_q    <= 16'h0000;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            slot_q   <= slot_d;
            lrck_q   <= lrck_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            lsr_q    <= lsr_d;
            rsr_q    <= rsr_d;
        end
    end

    assign i2s_bclk      = bclk_q;
    assign i2s_lrck      = lrck_q;
    assign i2s_data      = data_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_wts_i2s_transmitter.sv
// Directed bench for wts_i2s_transmitter: default divider instance plus a BCLK_HALF = 1 instance.
`timescale 1ns/1ps
module tb_wts_i2s_transmitter;

    logic        clk = 1'b0;
    logic        slot_nreset = 1'b0;
    logic [11:0] left_in = 12'h800;
    logic [11:0] right_in = 12'h800;
    logic        mute = 1'b0;
    logic        bclk0, lrck0, data0, st0;
    logic        bclk1, lrck1, data1, st1;

    int checks = 0;
    int errors = 0;

    wts_i2s_transmitter #(.BCLK_HALF(4)) dut0 (
        .clk(clk), .slot_nreset(slot_nreset), .left_in(left_in), .right_in(right_in),
        .mute(mute), .i2s_bclk(bclk0), .i2s_lrck(lrck0), .i2s_data(data0),
        .sample_strobe(st0)
    );

    wts_i2s_transmitter #(.BCLK_HALF(1)) dut1 (
        .clk(clk), .slot_nreset(slot_nreset), .left_in(left_in), .right_in(right_in),
        .mute(mute), .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_data(data1),
        .sample_strobe(st1)
    );

    initial forever #5 clk = ~clk;

    task automatic wait_strobe(input bit sel, output logic to);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? st1 : st0) && n < 2000);
        to = !(sel ? st1 : st0);
    endtask

    task automatic wait_rise(input bit sel, output logic to, output int cycles);
        logic prev, cur, rise;
        prev = sel ? bclk1 : bclk0;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            cur  = sel ? bclk1 : bclk0;
            rise = cur && !prev;
            prev = cur;
        end while (!rise && cycles < 64);
        to = !rise;
    endtask

    // Captures the frame that starts at the next strobe of dut0, sampled on BCLK rising edges.
    task automatic capture(input int chg_slot, input logic [11:0] chg_left, input logic chg_mute,
                           output logic [15:0] lw, output logic [15:0] rw,
                           output logic lr_ok, output logic zero_ok, output logic to);
        int c;
        lw = 16'h0; rw = 16'h0; lr_ok = 1'b1; zero_ok = 1'b1;
        wait_strobe(1'b0, to);
        if (to) return;
        for (int i = 0; i < 64; i++) begin
            wait_rise(1'b0, to, c);
            if (to) return;
            if (lrck0 !== (i >= 32)) lr_ok = 1'b0;
            if (i >= 1 && i <= 16) lw = {lw[14:0], data0};
            else if (i >= 33 && i <= 48) rw = {rw[14:0], data0};
            else if (data0 !== 1'b0) zero_ok = 1'b0;
            if (i == chg_slot) begin
                left_in = chg_left;
                mute    = chg_mute;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        slot_nreset = 1'b0;
        repeat (3) @(negedge clk);
        slot_nreset = 1'b1;
        n = 0;
        // Enter the left half with BCLK low so every reset value differs from the live one.
        do begin
            @(negedge clk);
            n++;
        end while (!(bclk0 == 1'b0 && lrck0 == 1'b0 && st0 == 1'b0) && n < 2000);
        slot_nreset = 1'b0;
        #1;
        checks++;
        if ({bclk0, lrck0, data0, st0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_async: got bclk/lrck/data/strobe=%b required 1100",
                     {bclk0, lrck0, data0, st0});
        end
        @(negedge clk);
        slot_nreset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if ({bclk0, st0} !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_edge3: got bclk/strobe=%b required 10", {bclk0, st0});
                end
            end else if (k == 4) begin
                checks++;
                if ({bclk0, lrck0, data0, st0} !== 4'b0001) begin
                    errors++;
                    $display("FAIL reset_edge4: got bclk/lrck/data/strobe=%b required 0001",
                             {bclk0, lrck0, data0, st0});
                end
            end else if (k == 8) begin
                checks++;
                if ({bclk0, st0} !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_edge8: got bclk/strobe=%b required 10", {bclk0, st0});
                end
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] lw, input logic [15:0] rw,
                               input logic lr_ok, input logic zero_ok, input logic to,
                               input logic [15:0] exp_l, input logic [15:0] exp_r);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: got timeout=%b required 0", name, to);
        end
        checks++;
        if (lw !== exp_l) begin
            errors++;
            $display("FAIL %s_left: got %h required %h", name, lw, exp_l);
        end
        checks++;
        if (rw !== exp_r) begin
            errors++;
            $display("FAIL %s_right: got %h required %h", name, rw, exp_r);
        end
        checks++;
        if ({lr_ok, zero_ok} !== 2'b11) begin
            errors++;
            $display("FAIL %s_layout: got lrck_ok/pad_zero=%b required 11", name, {lr_ok, zero_ok});
        end
    endtask

    task automatic test_stereo_frame;
        logic [15:0] lw, rw;
        logic lr_ok, zero_ok, to;
        left_in = 12'hFFF; right_in = 12'h000; mute = 1'b0;
        capture(-1, 12'hFFF, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("stereo", lw, rw, lr_ok, zero_ok, to, 16'h7FF0, 16'h8000);
        left_in = 12'h7FF; right_in = 12'h800;
        capture(-1, 12'h7FF, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("stereo2", lw, rw, lr_ok, zero_ok, to, 16'hFFF0, 16'h0000);
    endtask

    task automatic test_frame_rate;
        logic to;
        int n, c;
        for (int sel = 0; sel < 2; sel++) begin
            wait_strobe(sel[0], to);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(sel[0] ? st1 : st0) && n < 2000);
            checks++;
            if (n !== (sel == 0 ? 512 : 128)) begin
                errors++;
                $display("FAIL frame_period%0d: got %0d clks required %0d", sel, n,
                         (sel == 0 ? 512 : 128));
            end
            wait_rise(sel[0], to, c);
            wait_rise(sel[0], to, c);
            checks++;
            if (to !== 1'b0 || c !== (sel == 0 ? 8 : 2)) begin
                errors++;
                $display("FAIL bclk_period%0d: got %0d clks (timeout=%b) required %0d", sel, c, to,
                         (sel == 0 ? 8 : 2));
            end
        end
    endtask

    task automatic test_mute;
        logic [15:0] lw, rw;
        logic lr_ok, zero_ok, to;
        left_in = 12'hABC; right_in = 12'h123; mute = 1'b1;
        capture(10, 12'hABC, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("mute", lw, rw, lr_ok, zero_ok, to, 16'h0000, 16'h0000);
        capture(-1, 12'hABC, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("unmute", lw, rw, lr_ok, zero_ok, to, 16'h2BC0, 16'h9230);
    endtask

    task automatic test_midframe_change;
        logic [15:0] lw, rw;
        logic lr_ok, zero_ok, to;
        left_in = 12'h800; right_in = 12'h800; mute = 1'b0;
        capture(8, 12'hFFF, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("midchg", lw, rw, lr_ok, zero_ok, to, 16'h0000, 16'h0000);
        capture(-1, 12'hFFF, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("midchg_next", lw, rw, lr_ok, zero_ok, to, 16'h7FF0, 16'h0000);
    endtask

    task automatic test_reset_midshift;
        logic [15:0] lw, rw;
        logic lr_ok, zero_ok, to;
        int c;
        left_in = 12'hFFF; right_in = 12'h000; mute = 1'b0;
        wait_strobe(1'b0, to);
        for (int i = 0; i <= 40; i++) wait_rise(1'b0, to, c);
        // Slot 40: mid right-word shift, LRCK high.
        repeat (2) @(negedge clk);
        slot_nreset = 1'b0;
        #1;
        checks++;
        if ({bclk0, lrck0, data0, st0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_midshift: got bclk/lrck/data/strobe=%b required 1100",
                     {bclk0, lrck0, data0, st0});
        end
        left_in = 12'h7FF; right_in = 12'hFFF;
        @(negedge clk);
        slot_nreset = 1'b1;
        capture(-1, 12'h7FF, 1'b0, lw, rw, lr_ok, zero_ok, to);
        check_frame("post_reset", lw, rw, lr_ok, zero_ok, to, 16'hFFF0, 16'h7FF0);
    endtask

    initial begin
        test_reset();
        test_stereo_frame();
        test_frame_rate();
        test_mute();
        test_midframe_change();
        test_reset_midshift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
